// File: rtl/fm_rssi_scan_ctrl_if.sv
// Signal bundle between the channel-scan sequencer, its software/RSSI-accumulator
// side (master) and the sequencer itself (slave).
interface fm_rssi_scan_ctrl_if #(
    parameter int CH_WIDTH = 4
);
    logic                start;
    logic                abort;
    logic [CH_WIDTH-1:0] ch_first;
    logic [CH_WIDTH-1:0] ch_last;
    logic                RSSI_interrupt;
    logic [16:0]         rssi_sum;

    logic [3:0]          FM_HW_state;
    logic [CH_WIDTH-1:0] tune_ch;
    logic                tune_valid;
    logic [CH_WIDTH-1:0] best_ch;
    logic [16:0]         best_rssi;
    logic                best_valid;
    logic                busy;
    logic                done;
    logic                timeout_err;

    modport master (
        output start, abort, ch_first, ch_last, RSSI_interrupt, rssi_sum,
        input  FM_HW_state, tune_ch, tune_valid, best_ch, best_rssi,
               best_valid, busy, done, timeout_err
    );

    modport slave (
        input  start, abort, ch_first, ch_last, RSSI_interrupt, rssi_sum,
        output FM_HW_state, tune_ch, tune_valid, best_ch, best_rssi,
               best_valid, busy, done, timeout_err
    );
endinterface

// File: rtl/fm_rssi_scan_ctrl.sv
// Channel-scan sequencer: retunes each channel of a range, waits for the RSSI
// accumulator, and keeps the strongest channel seen.
module fm_rssi_scan_ctrl #(
    parameter int CH_WIDTH       = 4,
    parameter int NUM_CH         = 16,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic               clk,
    input  logic               RST,
    fm_rssi_scan_ctrl_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]    SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_WIDTH-1:0] LAST_CH      = CH_WIDTH'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TUNE,
        S_SETTLE,
        S_MEASURE,
        S_CAPTURE,
        S_NEXT,
        S_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [CH_WIDTH-1:0] tune_ch_q, tune_ch_d;
    logic [CH_WIDTH-1:0] ch_last_q, ch_last_d;
    logic [CH_WIDTH-1:0] best_ch_q, best_ch_d;
    logic [16:0]         best_rssi_q, best_rssi_d;
    logic                best_valid_q, best_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cap_q, cap_d;
    logic                irq_prev_q;
    logic                irq_rise;

    // The accumulator pulse may be several cycles wide; only its rising edge counts.
    assign irq_rise = bus.RSSI_interrupt && !irq_prev_q;

    always_comb begin
        // NOTE: every next-state value defaults to its current value so no path infers a latch.
        state_d       = state_q;
        tune_ch_d     = tune_ch_q;
        ch_last_d     = ch_last_q;
        best_ch_d     = best_ch_q;
        best_rssi_d   = best_rssi_q;
        best_valid_d  = best_valid_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        cap_d         = cap_q;

        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        tune_ch_d     = bus.ch_first;
                        ch_last_d     = bus.ch_last;
                        best_ch_d     = '0;
                        best_rssi_d   = '0;
                        best_valid_d  = 1'b0;
                        timeout_err_d = 1'b0;
                        state_d       = S_TUNE;
                    end
                end
                S_TUNE: begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_MEASURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (irq_rise) begin
                        cap_d   = 1'b0;
                        state_d = S_CAPTURE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_NEXT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Second cycle: the accumulator's registered read data is now valid.
                    if (cap_q) begin
                        if (!best_valid_q || bus.rssi_sum > best_rssi_q) begin
                            best_ch_d   = tune_ch_q;
                            best_rssi_d = bus.rssi_sum;
                        end
                        best_valid_d = 1'b1;
                        state_d      = S_NEXT;
                    end else begin
                        cap_d = 1'b1;
                    end
                end
                S_NEXT: begin
                    if (tune_ch_q == ch_last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        tune_ch_d = (tune_ch_q == LAST_CH) ? '0 : tune_ch_q + 1'b1;
                        state_d   = S_TUNE;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.FM_HW_state = 4'b1000;
        unique case (state_q)
            S_IDLE:               bus.FM_HW_state = 4'b0000;
            S_MEASURE, S_CAPTURE: bus.FM_HW_state = 4'b0100;
            default:              bus.FM_HW_state = 4'b1000;
        endcase
    end

    assign bus.tune_ch     = tune_ch_q;
    assign bus.tune_valid  = (state_q == S_TUNE);
    assign bus.best_ch     = best_ch_q;
    assign bus.best_rssi   = best_rssi_q;
    assign bus.best_valid  = best_valid_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_FINISH);
    assign bus.timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from pre-edge values.
        if (RST) begin
            state_q       <= S_IDLE;
            tune_ch_q     <= '0;
            ch_last_q     <= '0;
            best_ch_q     <= '0;
            best_rssi_q   <= '0;
            best_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            cap_q         <= 1'b0;
            irq_prev_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tune_ch_q     <= tune_ch_d;
            ch_last_q     <= ch_last_d;
            best_ch_q     <= best_ch_d;
            best_rssi_q   <= best_rssi_d;
            best_valid_q  <= best_valid_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            cap_q         <= cap_d;
            irq_prev_q    <= bus.RSSI_interrupt;
        end
    end
endmodule

// File: tb/tb_fm_rssi_scan_ctrl.sv
// Scoreboard bench: a channel-list model predicts tune strobes and scan results,
// a monitor compares them as the sequencer presents tune_valid and done.
module tb_fm_rssi_scan_ctrl;
    localparam int CH_WIDTH = 4;
    localparam int NUM_CH   = 16;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 64;
    localparam logic [16:0] GARBAGE = 17'h1FFFF;

    typedef struct {
        int ch;
        int rssi;
        int valid;
        int terr;
    } res_t;

    logic clk = 1'b0;
    logic RST;

    fm_rssi_scan_ctrl_if #(.CH_WIDTH(CH_WIDTH)) bus ();

    fm_rssi_scan_ctrl #(
        .CH_WIDTH      (CH_WIDTH),
        .NUM_CH        (NUM_CH),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_tune[$];
    res_t exp_res[$];
    res_t exp_r;
    int   rssi_tab[NUM_CH];
    bit   no_irq[NUM_CH];
    int   irq_w = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_tables(input bit randomize_vals);
        for (int i = 0; i < NUM_CH; i++) begin
            no_irq[i]   = 1'b0;
            rssi_tab[i] = randomize_vals ? int'($urandom_range(0, 7)) * 1000 : 0;
        end
    endtask

    // Walk the range as the scan would, predicting strobes and the winner.
    task automatic expect_scan(input int first, input int last, input int abort_at);
        int   c;
        res_t r;
        r = '{default: 0};
        c = first;
        forever begin
            exp_tune.push_back(c);
            if (c == abort_at) break;
            if (no_irq[c]) r.terr = 1;
            else begin
                if (r.valid == 0 || rssi_tab[c] > r.rssi) begin
                    r.ch   = c;
                    r.rssi = rssi_tab[c];
                end
                r.valid = 1;
            end
            if (c == last) break;
            c = (c + 1) % NUM_CH;
        end
        exp_r = r;
        if (abort_at < 0) exp_res.push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hw_state"},   32'(bus.FM_HW_state), 0);
        check({tag, "_tune_ch"},    32'(bus.tune_ch), 0);
        check({tag, "_tune_valid"}, 32'(bus.tune_valid), 0);
        check({tag, "_best_ch"},    32'(bus.best_ch), 0);
        check({tag, "_best_rssi"},  32'(bus.best_rssi), 0);
        check({tag, "_best_valid"}, 32'(bus.best_valid), 0);
        check({tag, "_busy"},       32'(bus.busy), 0);
        check({tag, "_done"},       32'(bus.done), 0);
        check({tag, "_timeout"},    32'(bus.timeout_err), 0);
    endtask

    task automatic check_best(input string tag);
        check({tag, "_best_ch"},    32'(bus.best_ch), exp_r.ch);
        check({tag, "_best_rssi"},  32'(bus.best_rssi), exp_r.rssi);
        check({tag, "_best_valid"}, 32'(bus.best_valid), exp_r.valid);
        check({tag, "_timeout"},    32'(bus.timeout_err), exp_r.terr);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_in_budget"}, 32'(bus.busy), 0);
    endtask

    task automatic run_scan(input string tag, input int first, input int last, input bit timing);
        bus.ch_first = CH_WIDTH'(first);
        bus.ch_last  = CH_WIDTH'(last);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (timing) begin
            check({tag, "_tune_strobe"}, 32'(bus.tune_valid), 1);
            check({tag, "_tune_hw"},     32'(bus.FM_HW_state), 32'h8);
            for (int i = 0; i < SETTLE; i++) begin
                @(negedge clk);
                check({tag, "_settle_hw"}, 32'(bus.FM_HW_state), 32'h8);
            end
            @(negedge clk);
            check({tag, "_measure_hw"}, 32'(bus.FM_HW_state), 32'h4);
        end
        @(negedge clk);
        wait_idle(tag, 20000);
        check_best({tag, "_hold"});
    endtask

    // Accumulator model: answers each MEASURE with a pulse; rssi_sum carries the
    // real value only at the edge two cycles after the pulse is first sampled.
    initial begin : accumulator
        int ch;
        int w;
        bus.RSSI_interrupt = 1'b0;
        bus.rssi_sum       = GARBAGE;
        forever begin
            @(negedge clk);
            if (bus.tune_valid) begin
                ch = int'(bus.tune_ch);
                while (bus.busy && bus.FM_HW_state != 4'b0100) @(negedge clk);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                if (bus.busy && bus.FM_HW_state == 4'b0100 && !no_irq[ch]) begin
                    w = (irq_w == 0) ? int'($urandom_range(1, 3)) : irq_w;
                    bus.RSSI_interrupt = 1'b1;
                    for (int k = 1; k <= 3; k++) begin
                        @(negedge clk);
                        bus.RSSI_interrupt = (k < w);
                        bus.rssi_sum       = (k == 2) ? 17'(rssi_tab[ch]) : GARBAGE;
                    end
                end
            end
        end
    end

    initial begin : monitor
        int   e;
        res_t r;
        forever begin
            @(negedge clk);
            if (!RST && bus.tune_valid) begin
                if (exp_tune.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tune_unexpected: got ch %0d expected no strobe", bus.tune_ch);
                end else begin
                    e = exp_tune.pop_front();
                    check("tune_ch", 32'(bus.tune_ch), e);
                end
            end
            if (!RST && bus.done) begin
                if (exp_res.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected: got done=1 expected 0");
                end else begin
                    r = exp_res.pop_front();
                    check("done_best_ch",    32'(bus.best_ch), r.ch);
                    check("done_best_rssi",  32'(bus.best_rssi), r.rssi);
                    check("done_best_valid", 32'(bus.best_valid), r.valid);
                    check("done_timeout",    32'(bus.timeout_err), r.terr);
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        int first;
        int last;
        RST          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.ch_first = '0;
        bus.ch_last  = '0;
        clear_tables(1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("por");
        RST = 1'b0;
        @(negedge clk);

        // Directed range with a tie: the earlier channel must win.
        clear_tables(1'b0);
        rssi_tab[2] = 100;
        rssi_tab[3] = 300;
        rssi_tab[4] = 300;
        rssi_tab[5] = 50;
        expect_scan(2, 5, -1);
        run_scan("r2_5", 2, 5, 1'b1);

        // Reset in the middle of MEASURE.
        clear_tables(1'b0);
        no_irq[9] = 1'b1;
        exp_tune.push_back(9);
        bus.ch_first = 4'd9;
        bus.ch_last  = 4'd9;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.FM_HW_state != 4'b0100 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_measure", 32'(bus.FM_HW_state), 32'h4);
        repeat (5) @(negedge clk);
        RST = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("midrst");
        RST = 1'b0;
        @(negedge clk);

        // Wrapping range.
        clear_tables(1'b1);
        expect_scan(14, 1, -1);
        run_scan("wrap", 14, 1, 1'b0);

        // Timeout on the middle channel.
        clear_tables(1'b1);
        no_irq[7]   = 1'b1;
        rssi_tab[7] = 17'h1FFFE;
        expect_scan(6, 8, -1);
        run_scan("tmo", 6, 8, 1'b0);

        // Abort during channel 3 with start held high through the early scan.
        clear_tables(1'b1);
        no_irq[3] = 1'b1;
        expect_scan(0, 5, 3);
        bus.ch_first = 4'd0;
        bus.ch_last  = 4'd5;
        bus.start    = 1'b1;
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!(bus.tune_ch == 4'd3 && bus.FM_HW_state == 4'b0100) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_ch3", 32'(bus.tune_ch == 4'd3 && bus.FM_HW_state == 4'b0100), 1);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_hw",   32'(bus.FM_HW_state), 0);
        check_best("abort");
        repeat (20) @(negedge clk);

        // Wide interrupt: one capture, sampled two edges after the rise.
        irq_w = 3;
        clear_tables(1'b1);
        expect_scan(10, 13, -1);
        run_scan("wide", 10, 13, 1'b0);
        irq_w = 0;

        // Randomized ranges, values with frequent ties, occasional timeouts.
        for (int s = 0; s < 6; s++) begin
            clear_tables(1'b1);
            for (int i = 0; i < NUM_CH; i++) no_irq[i] = ($urandom_range(0, 7) == 0);
            first = int'($urandom_range(0, NUM_CH - 1));
            last  = int'($urandom_range(0, NUM_CH - 1));
            expect_scan(first, last, -1);
            run_scan("rand", first, last, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("tune_queue_drained", 32'(exp_tune.size()), 0);
        check("done_queue_drained", 32'(exp_res.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
